// File: rtl/gat_param_loader.sv
// gat_param_loader: streams a layer's W matrix and attention vector a from
// the shared weight BRAM into flat register arrays, with a start/busy/done
// handshake so the same block reloads parameters for successive layers.
// Optional feature macro: GAT_PARAM_LOADER_SHADOW_EN (capture into shadow
// arrays and publish them atomically when the load completes).
module gat_param_loader #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_ROWS     = 16,
  parameter int NUM_COLS     = 7,
  parameter int A_DEPTH      = 2*NUM_COLS,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_W       = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start_i,
  input  logic [ADDR_W-1:0]                       base_addr_i,
  output logic                                    bram_en_o,
  output logic [ADDR_W-1:0]                       bram_addr_o,
  input  logic [DATA_WIDTH-1:0]                   bram_dout_i,
  output logic [NUM_COLS*NUM_ROWS*DATA_WIDTH-1:0] wgt_o,
  output logic [A_DEPTH*DATA_WIDTH-1:0]           a_o,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    rdy_o
);

  localparam int W_N     = NUM_ROWS*NUM_COLS;
  localparam int N_TOTAL = W_N + A_DEPTH;
  localparam int CNT_W   = $clog2(N_TOTAL+1);
  localparam int ROW_W   = $clog2(NUM_ROWS+1);
  localparam int COL_W   = $clog2(NUM_COLS+1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       base_q;
  logic [CNT_W-1:0]        iss_cnt;
  logic [CNT_W-1:0]        cap_cnt;
  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic [BRAM_LATENCY-1:0] vld;
  logic                    tail;
  logic                    last_cap;

`ifdef GAT_PARAM_LOADER_SHADOW_EN
  logic [NUM_COLS*NUM_ROWS*DATA_WIDTH-1:0] wgt_sh;
  logic [A_DEPTH*DATA_WIDTH-1:0]           a_sh;
`endif

  assign tail     = vld[BRAM_LATENCY-1];
  assign last_cap = tail && (cap_cnt == CNT_W'(N_TOTAL-1));

  // Control FSM: issues one BRAM read per cycle, then waits for the last capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_q      <= '0;
      iss_cnt     <= '0;
      bram_en_o   <= 1'b0;
      bram_addr_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rdy_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= ISSUE;
            base_q      <= base_addr_i;
            bram_addr_o <= base_addr_i;
            bram_en_o   <= 1'b1;
            iss_cnt     <= CNT_W'(1);
            busy_o      <= 1'b1;
`ifndef GAT_PARAM_LOADER_SHADOW_EN
            rdy_o       <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          // iss_cnt holds the next offset; address k=0 went out on the accepting edge
          if (iss_cnt == CNT_W'(N_TOTAL)) begin
            bram_en_o <= 1'b0;
            state     <= DRAIN;
          end else begin
            bram_addr_o <= base_q + ADDR_W'(iss_cnt);
            iss_cnt     <= iss_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          // leave on the edge of the final capture so done_o follows it directly
          if (last_cap || (cap_cnt == CNT_W'(N_TOTAL))) begin
            state  <= DONE;
            done_o <= 1'b1;
            rdy_o  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture path: read-valid pipeline, element counters and the W/a storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      cap_cnt <= '0;
      row     <= '0;
      col     <= '0;
      wgt_o   <= '0;
      a_o     <= '0;
`ifdef GAT_PARAM_LOADER_SHADOW_EN
      wgt_sh  <= '0;
      a_sh    <= '0;
`endif
    end else begin
      vld[0] <= bram_en_o;
      for (int unsigned i = 1; i < BRAM_LATENCY; i++) vld[i] <= vld[i-1];

      if (state == IDLE && start_i) begin
        cap_cnt <= '0;
        row     <= '0;
        col     <= '0;
      end else if (tail && (cap_cnt < CNT_W'(N_TOTAL))) begin
        cap_cnt <= cap_cnt + CNT_W'(1);
        if (cap_cnt < CNT_W'(W_N)) begin
          // row/col counters walk e = row*NUM_COLS + col with the column fastest
          for (int unsigned c = 0; c < NUM_COLS; c++)
            for (int unsigned r = 0; r < NUM_ROWS; r++)
              if (col == COL_W'(c) && row == ROW_W'(r))
`ifdef GAT_PARAM_LOADER_SHADOW_EN
                wgt_sh[(c*NUM_ROWS+r)*DATA_WIDTH +: DATA_WIDTH] <= bram_dout_i;
`else
                wgt_o[(c*NUM_ROWS+r)*DATA_WIDTH +: DATA_WIDTH] <= bram_dout_i;
`endif
          if (col == COL_W'(NUM_COLS-1)) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end else begin
          for (int unsigned i = 0; i < A_DEPTH; i++)
            if (cap_cnt == CNT_W'(W_N+i))
`ifdef GAT_PARAM_LOADER_SHADOW_EN
              a_sh[i*DATA_WIDTH +: DATA_WIDTH] <= bram_dout_i;
`else
              a_o[i*DATA_WIDTH +: DATA_WIDTH] <= bram_dout_i;
`endif
        end
      end

`ifdef GAT_PARAM_LOADER_SHADOW_EN
      if (state == DONE) begin
        wgt_o <= wgt_sh;
        a_o   <= a_sh;
      end
`endif
    end
  end

endmodule
